// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side handshake bundle for mem_arbiter.
// slave is the arbiter's view; master is the view of the caches and RAM around it.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache single-word requests onto one RAM port; dcache first, with a starvation guard.
// Optional MEM_STATS_EN builds saturating completion counters on istat_cnt/dstat_cnt.
//
// state | meaning
// IDLE  | no access held; owner picked combinationally and driven this cycle
// DSERV | dcache owns the RAM port until ACCESS or request drop
// ISERV | icache owns the RAM port until ACCESS or request drop
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    mem_arbiter_if.slave     bus,
    output logic [31:0]      istat_cnt,
    output logic [31:0]      dstat_cnt
);
    localparam int SW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I} owner_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    owner_t        owner;
    logic          d_req, starve, access, d_done, i_done;

    always_comb begin
        d_req  = bus.dREN | bus.dWEN;
        starve = bus.iREN && (streak_q == STREAK_MAX);
        access = (bus.ramstate == RAM_ACCESS);
        owner  = OWN_NONE;
        // Held low in reset so the RAM port releases as soon as nRST falls.
        if (nRST) begin
            case (state_q)
                IDLE: begin
                    if (d_req && !starve)  owner = OWN_D;
                    else if (bus.iREN)     owner = OWN_I;
                end
                DSERV:   if (d_req)    owner = OWN_D;
                ISERV:   if (bus.iREN) owner = OWN_I;
                default: owner = OWN_NONE;
            endcase
        end
        d_done = (owner == OWN_D) && access;
        i_done = (owner == OWN_I) && access;
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        if (owner == OWN_D) begin
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
        end else if (owner == OWN_I) begin
            bus.ramREN   = 1'b1;
            bus.ramaddr  = bus.iaddr;
        end
        bus.dwait = d_req & ~d_done;
        bus.iwait = bus.iREN & ~i_done;
        bus.dload = d_done ? bus.ramload : 32'h0;
        bus.iload = i_done ? bus.ramload : 32'h0;
    end

    always_comb begin
        state_d = IDLE;
        if (owner == OWN_D && !d_done) state_d = DSERV;
        if (owner == OWN_I && !i_done) state_d = ISERV;

        streak_d = streak_q;
        if (!bus.iREN || owner == OWN_I)            streak_d = '0;
        else if (d_done && streak_q != STREAK_MAX)  streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] istat_q, istat_d, dstat_q, dstat_d;

    always_comb begin
        istat_d = istat_q;
        dstat_d = dstat_q;
        if (i_done && istat_q != 32'hFFFF_FFFF) istat_d = istat_q + 32'd1;
        if (d_done && dstat_q != 32'hFFFF_FFFF) dstat_d = dstat_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            istat_q <= 32'h0;
            dstat_q <= 32'h0;
        end else begin
            istat_q <= istat_d;
            dstat_q <= dstat_d;
        end
    end

    assign istat_cnt = istat_q;
    assign dstat_cnt = dstat_q;
`else
    assign istat_cnt = 32'h0;
    assign dstat_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: IDLE-cycle vector table plus multi-cycle sequences.
// Stat counter checks follow MEM_STATS_EN the same way the design does.
module tb_mem_arbiter;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] istat_cnt, dstat_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .istat_cnt (istat_cnt),
        .dstat_cnt (dstat_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren, dren, dwen;
        logic [31:0] iaddr, daddr, dstore, ramload;
        logic [1:0]  ramstate;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iwait, e_dwait;
        logic [31:0] e_iload, e_dload;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [131:0] got, input logic [131:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.iREN = 1'b0; bus.iaddr = 32'h0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
        bus.ramload = 32'h0; bus.ramstate = FREE;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [131:0] port_bundle();
        return {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore,
                bus.iwait, bus.dwait, bus.iload, bus.dload};
    endfunction

    initial begin
        vecs[0] = '{1'b0,1'b0,1'b0, 32'h1,32'h2,32'h3,32'h4, ACC,
                    1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b0, 32'h0,32'h0};
        vecs[1] = '{1'b0,1'b1,1'b0, 32'h0,32'h40,32'h0,32'hDEADBEEF, ACC,
                    1'b1,1'b0, 32'h40,32'h0, 1'b0,1'b0, 32'h0,32'hDEADBEEF};
        vecs[2] = '{1'b1,1'b0,1'b0, 32'h100,32'h0,32'h55,32'h1234, ACC,
                    1'b1,1'b0, 32'h100,32'h0, 1'b0,1'b0, 32'h1234,32'h0};
        vecs[3] = '{1'b1,1'b1,1'b0, 32'h100,32'h200,32'h0,32'hAA, ACC,
                    1'b1,1'b0, 32'h200,32'h0, 1'b1,1'b0, 32'h0,32'hAA};
        vecs[4] = '{1'b0,1'b1,1'b1, 32'h0,32'h3100,32'h5,32'h0, ACC,
                    1'b0,1'b1, 32'h3100,32'h5, 1'b0,1'b0, 32'h0,32'h0};
        vecs[5] = '{1'b0,1'b1,1'b0, 32'h0,32'h44,32'h0,32'h99, BUSY,
                    1'b1,1'b0, 32'h44,32'h0, 1'b0,1'b1, 32'h0,32'h0};
        vecs[6] = '{1'b1,1'b0,1'b0, 32'h108,32'h0,32'h0,32'h99, ERR,
                    1'b1,1'b0, 32'h108,32'h0, 1'b1,1'b0, 32'h0,32'h0};
        vecs[7] = '{1'b0,1'b0,1'b1, 32'h0,32'h48,32'hCAFE,32'h0, FREE,
                    1'b0,1'b1, 32'h48,32'hCAFE, 1'b0,1'b1, 32'h0,32'h0};
        vecs[8] = '{1'b1,1'b0,1'b1, 32'h10C,32'h4C,32'h7,32'h0, BUSY,
                    1'b0,1'b1, 32'h4C,32'h7, 1'b1,1'b1, 32'h0,32'h0};

        nRST = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);

        // IDLE-cycle vectors, each from a fresh reset so state and streak start at 0.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            bus.iREN = vecs[i].iren; bus.dREN = vecs[i].dren; bus.dWEN = vecs[i].dwen;
            bus.iaddr = vecs[i].iaddr; bus.daddr = vecs[i].daddr; bus.dstore = vecs[i].dstore;
            bus.ramload = vecs[i].ramload; bus.ramstate = vecs[i].ramstate;
            @(negedge CLK);
            chk($sformatf("vec%0d", i), port_bundle(),
                {vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_store,
                 vecs[i].e_iwait, vecs[i].e_dwait, vecs[i].e_iload, vecs[i].e_dload});
        end

        // Single dcache read: BUSY, BUSY, ACCESS.
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h40; bus.ramstate = BUSY;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin bus.ramstate = ACC; bus.ramload = 32'hDEADBEEF; end
            @(negedge CLK);
            chk($sformatf("dread_c%0d", c), {bus.ramREN, bus.ramaddr, bus.dwait, bus.dload},
                {1'b1, 32'h40, (c != 2), (c == 2) ? 32'hDEADBEEF : 32'h0});
            next_cycle();
        end
        bus.dREN = 1'b0; bus.ramstate = FREE;
        @(negedge CLK);
        chk("dread_release", {bus.ramREN, bus.ramWEN, bus.dwait}, 3'b000);
        next_cycle();

        // Simultaneous requests with a 1-cycle RAM.
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h100;
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        bus.ramstate = ACC; bus.ramload = 32'h77;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            chk($sformatf("simul_d%0d", c), {bus.iwait, bus.dwait, bus.ramaddr, bus.dload},
                {1'b1, 1'b0, 32'h200, 32'h77});
            next_cycle();
        end
        bus.dREN = 1'b0;
        @(negedge CLK);
        chk("simul_i", {bus.iwait, bus.ramaddr, bus.iload, bus.dload},
            {1'b0, 32'h100, 32'h77, 32'h0});
        next_cycle();

        // Starvation guard: four dcache completions, one icache, repeat.
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h500;
        bus.dREN = 1'b1; bus.daddr = 32'h600;
        bus.ramstate = ACC; bus.ramload = 32'h1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (k % 5 == 4)
                chk($sformatf("starve_k%0d", k), {bus.iwait, bus.dwait, bus.ramaddr},
                    {1'b0, 1'b1, 32'h500});
            else
                chk($sformatf("starve_k%0d", k), {bus.iwait, bus.dwait, bus.ramaddr},
                    {1'b1, 1'b0, 32'h600});
            next_cycle();
        end
        @(negedge CLK);
`ifdef MEM_STATS_EN
        chk("stats_after_starve", {istat_cnt, dstat_cnt}, {32'd2, 32'd10});
`else
        chk("stats_tied_off", {istat_cnt, dstat_cnt}, 64'h0);
`endif

        // Reset in the middle of a dcache access held in DSERV.
        next_cycle();
        bus.iREN = 1'b0; bus.dREN = 1'b1; bus.daddr = 32'h900; bus.ramstate = BUSY;
        next_cycle();
        @(negedge CLK);
        chk("rst_mid_pre", {bus.ramREN, bus.ramaddr, bus.dwait}, {1'b1, 32'h900, 1'b1});
        @(posedge CLK);
        #1 nRST = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_mid_en", {bus.ramREN, bus.ramWEN}, 2'b00);
        chk("rst_mid_stats", {istat_cnt, dstat_cnt}, 64'h0);
        nRST = 1'b1; bus.dREN = 1'b0; bus.ramstate = FREE;
        next_cycle();

        // Owner drops its request while held in DSERV with the RAM busy.
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = BUSY;
        @(negedge CLK);
        chk("drop_idle", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h80});
        next_cycle();
        @(negedge CLK);
        chk("drop_dserv", {bus.ramREN, bus.dwait}, {1'b1, 1'b1});
        next_cycle();
        bus.dREN = 1'b0;
        @(negedge CLK);
        chk("drop_release", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.dwait}, {1'b0, 1'b0, 32'h0, 1'b0});
        next_cycle();
        @(negedge CLK);
        chk("drop_stats", {istat_cnt, dstat_cnt}, 64'h0);
        next_cycle();
        bus.iREN = 1'b1; bus.iaddr = 32'h104; bus.ramstate = ACC; bus.ramload = 32'h3C;
        @(negedge CLK);
        chk("drop_back_idle", {bus.iwait, bus.ramREN, bus.ramaddr, bus.iload},
            {1'b0, 1'b1, 32'h104, 32'h3C});
        next_cycle();
        clear_inputs();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
